io_ports: RTL and testbench
===========================

# io_ports

Parametrised memory-mapped peripheral port block for the AVR core. It decodes a window of 10 I/O addresses starting at `BASE` and provides:
- a keyboard FIFO with status and overflow reporting;
- a programmable-rate tick timer;
- a VBLANK flag;
- border and video-page registers;
- a handshaked SD-card command sequencer with LBA and status registers;
- optionally, a maskable interrupt request.

It sits between the CPU I/O bus and the keyboard, video and SD controllers.

## Interface
- `BASE`, 16'h0020: first port address; all offsets below are relative to it, with an exact 16-bit match.
- `KBD_DEPTH`, 8: keyboard FIFO depth. Must be a power of two, 2..16.
- `CLK_HZ`, 25000000: input clock frequency.
- `TIMER_HZ`, 100: timer tick rate; `DIV = CLK_HZ/TIMER_HZ`, which must be ≥ 2.
- `clock`  in  1: system clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `a`  in  16: port address.
- `o`  in  8: write data.
- `r` / `w`  in  1: read / write strobes, one cycle each.
- `p`  out  8: read data, combinational from `a` and state.
- `sd_command`  out  1: SD request.
- `sd_rw`  out  1: 0 = read, 1 = write.
- `sd_lba`  out  32: sector address.
- `sd_card`  in  2: detected card type.
- `sd_error`  in  4: error code.
- `sd_done`  in  1: one-cycle completion pulse.
- `sd_busy`  in  1: controller busy.
- `p_vpage`  out  1: video page select.
- `p_border`  out  3: border colour.
- `p_vblank`  in  1: frame-end pulse.
- `p_kdone`  in  1: key-received pulse.
- `p_ascii`  in  8: key code.
- `irq`  out  1: interrupt request, level.

## Operation
- +0 R: keyboard FIFO head, or 8'h00 if the FIFO is empty; a read pops one entry when the FIFO is non-empty. +0 W: `p_border <= o[2:0]`.
- +1 R: 8-bit timer count. +1 W: `p_vpage <= o[0]`.
- +2 R: keyboard status. `[0]` = non-empty; `[1]` = overflow, sticky and cleared by this read; `[7:4]` = entry count, saturating at 15.
- +3 R: `{7'b0, vblank}`, flag cleared by the read. +3 W: IRQ mask `[3:0]`.
- +4..+7: `sd_lba` bytes 0..3, little-endian; both R and W.
- +8 W: start an SD command with `sd_rw <= o[0]`; accepted only in state IDLE, otherwise ignored. +8 R: `{sd_error, sd_card, done, busy}`. `busy` = FSM not IDLE, or `sd_busy`. `done` is a sticky flag cleared by this read.
- +9 R: IRQ pending `[3:0]`. +9 W: write-1-to-clear pending bits.
- Unmapped addresses: reads return 8'h00; writes have no effect.
- Keyboard FIFO:
  - `p_kdone` pushes `p_ascii`.
  - A push when full drops the new key and sets overflow.
  - A push and pop in the same cycle when full succeed together; overflow is not set.
- Timer: the prescaler counts 0..DIV-1. On wrap, the 8-bit count increments, wrapping 255 → 0.
- SD FSM:
  - IDLE: a write to +8 moves to REQ.
  - REQ: drive `sd_command = 1` until `sd_busy = 1` is sampled, then move to WAIT.
  - WAIT: on `sd_done`, set `done` and return to IDLE.
  - `sd_rw` and `sd_lba` are held stable from REQ through WAIT; LBA writes during REQ/WAIT are ignored.
- Flag set/clear collisions: for the vblank, done, overflow and pending flags, a set event in the same cycle as its clearing read or write wins, and the flag stays 1.
- Reset values: `p`-side state is zeroed. `sd_command`, `sd_rw`, `sd_lba`, `p_border`, `p_vpage` and `irq` are all 0. The FIFO is empty, the timer and prescaler are 0, all flags and the mask are 0, and the FSM is IDLE. Asserting reset mid-SD-operation abandons it; `sd_command` drops immediately, asynchronously.

## Timing
- Reads: `p` is valid in the same cycle `a` is presented. Side effects (pop, flag clear) take effect at the clock edge where `r = 1`.
- Writes: registers update at the edge where `w = 1`; the outputs show the new value from the next cycle.
- `p_kdone` at edge N: the key is readable at +0, and counted at +2, from cycle N+1.
- SD write to +8 at edge N: `sd_command = 1` from N+1. It falls on the edge after `sd_busy` is first sampled high.
- Timer: the first increment occurs DIV clocks after reset release.

## Configuration
- `IO_IRQ_EN` defined: the pending bits are set as follows.
  - `[0]`: key pushed.
  - `[1]`: vblank.
  - `[2]`: timer tick.
  - `[3]`: SD done.
  
  `irq = |(pending & mask)`, registered.
- `IO_IRQ_EN` undefined: `irq` is tied to 0; +3 and +9 writes are ignored; +9 reads 8'h00. No pending or mask flops are built.

## Test plan
- Reset with `reset_n = 0` mid-run → all outputs 0. +2 reads 8'h00; +8 reads `{sd_error, sd_card, 2'b00}`.
- Push 'A', 'B' (8'h41, 8'h42) → +2 reads 8'h21. Reads at +0 return 8'h41, 8'h42, then 8'h00; +2 then reads 8'h00.
- With `KBD_DEPTH = 8`, push 9 keys → +2 reads 8'h83, then 8'h81 on the next read. Simultaneous push+pop when full → no overflow, count stays 8.
- Write LBA 32'h12345678 via +4..+7, then write 8'h01 to +8 → `sd_command` high until `sd_busy` rises, with `sd_rw = 1`. A second +8 write is ignored. `sd_done` → +8 `done` bit reads 1, then 0 on a re-read.
- `CLK_HZ = 1000`, `TIMER_HZ = 100` → +1 increments every 10 clocks and wraps 255 → 0 after 2560 clocks.
- With `IO_IRQ_EN`: mask 4'b0010, pulse `p_vblank` → `irq = 1` next cycle. Write 8'h02 to +9 → `irq = 0`. A key push with mask bit 0 clear → `irq` stays 0.

Source files
------------

// File: rtl/io_ports.sv
// io_ports: ten-port CPU I/O window at BASE for keyboard FIFO, tick timer, vblank flag,
// video registers and SD command sequencer. Define IO_IRQ_EN to build the maskable interrupt.
module io_ports #(
   parameter logic [15:0] BASE      = 16'h0020,
   parameter int          KBD_DEPTH = 8,
   parameter int          CLK_HZ    = 25000000,
   parameter int          TIMER_HZ  = 100
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] a,
   input  logic [7:0]  o,
   input  logic        r,
   input  logic        w,
   output logic [7:0]  p,
   output logic        sd_command,
   output logic        sd_rw,
   output logic [31:0] sd_lba,
   input  logic [1:0]  sd_card,
   input  logic [3:0]  sd_error,
   input  logic        sd_done,
   input  logic        sd_busy,
   output logic        p_vpage,
   output logic [2:0]  p_border,
   input  logic        p_vblank,
   input  logic        p_kdone,
   input  logic [7:0]  p_ascii,
   output logic        irq
);

   localparam int DIV = CLK_HZ / TIMER_HZ;
   localparam int PW  = $clog2(KBD_DEPTH);
   localparam int DW  = $clog2(DIV);

   typedef enum logic [1:0] {SD_IDLE, SD_REQ, SD_WAIT} sd_state_t;

   logic [15:0] off;
   logic        in_win;
   logic [3:0]  idx;

   // The subtraction wraps addresses below BASE to large values, so one compare bounds the window.
   assign off    = a - BASE;
   assign in_win = (off < 16'd10);
   assign idx    = off[3:0];

   logic       rd_kbd, rd_stat, rd_vb, rd_sd;
   logic       wr_border, wr_vpage, wr_cmd;
   logic [3:0] wr_lba;

   assign rd_kbd    = r && in_win && (idx == 4'd0);
   assign rd_stat   = r && in_win && (idx == 4'd2);
   assign rd_vb     = r && in_win && (idx == 4'd3);
   assign rd_sd     = r && in_win && (idx == 4'd8);
   assign wr_border = w && in_win && (idx == 4'd0);
   assign wr_vpage  = w && in_win && (idx == 4'd1);
   assign wr_cmd    = w && in_win && (idx == 4'd8);
   assign wr_lba[0] = w && in_win && (idx == 4'd4);
   assign wr_lba[1] = w && in_win && (idx == 4'd5);
   assign wr_lba[2] = w && in_win && (idx == 4'd6);
   assign wr_lba[3] = w && in_win && (idx == 4'd7);

   logic [7:0]  kbd_mem [KBD_DEPTH];
   logic [PW-1:0] head, tail;
   logic [PW:0]   count;
   logic [4:0]    count_ext;
   logic [3:0]    kbd_level;
   logic          kbd_full, kbd_pop, kbd_push, ovf_set, kbd_ovf;

   // A pop frees a slot in the same cycle, so a push into a full FIFO still lands when paired with a read.
   assign kbd_full  = (count == (PW+1)'(KBD_DEPTH));
   assign kbd_pop   = rd_kbd && (count != '0);
   assign kbd_push  = p_kdone && (!kbd_full || kbd_pop);
   assign ovf_set   = p_kdone && kbd_full && !kbd_pop;
   assign count_ext = 5'(count);
   assign kbd_level = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];

   always_ff @(posedge clock) begin
      if (kbd_push) kbd_mem[tail] <= p_ascii;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         kbd_ovf <= 1'b0;
      end else begin
         if (kbd_push) tail <= tail + 1'b1;
         if (kbd_pop)  head <= head + 1'b1;
         if (kbd_push && !kbd_pop)      count <= count + 1'b1;
         else if (!kbd_push && kbd_pop) count <= count - 1'b1;
         if (ovf_set)      kbd_ovf <= 1'b1;
         else if (rd_stat) kbd_ovf <= 1'b0;
      end
   end

   logic [DW-1:0] pre;
   logic [7:0]    tcount;
   logic          tick;

   assign tick = (pre == DW'(DIV - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pre    <= '0;
         tcount <= '0;
      end else if (tick) begin
         pre    <= '0;
         tcount <= tcount + 1'b1;
      end else begin
         pre    <= pre + 1'b1;
      end
   end

   logic vblank;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vblank   <= 1'b0;
         p_border <= 3'd0;
         p_vpage  <= 1'b0;
      end else begin
         if (p_vblank)   vblank <= 1'b1;
         else if (rd_vb) vblank <= 1'b0;
         if (wr_border) p_border <= o[2:0];
         if (wr_vpage)  p_vpage  <= o[0];
      end
   end

   sd_state_t sd_state;
   logic      done, done_set, busy_flag;

   assign done_set  = (sd_state == SD_WAIT) && sd_done;
   assign busy_flag = (sd_state != SD_IDLE) || sd_busy;

   // LBA and direction only change in IDLE, keeping them stable for the controller through REQ and WAIT.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sd_state   <= SD_IDLE;
         sd_command <= 1'b0;
         sd_rw      <= 1'b0;
         sd_lba     <= 32'd0;
         done       <= 1'b0;
      end else begin
         if (done_set)   done <= 1'b1;
         else if (rd_sd) done <= 1'b0;
         case (sd_state)
            SD_IDLE: begin
               if (wr_lba[0]) sd_lba[7:0]   <= o;
               if (wr_lba[1]) sd_lba[15:8]  <= o;
               if (wr_lba[2]) sd_lba[23:16] <= o;
               if (wr_lba[3]) sd_lba[31:24] <= o;
               if (wr_cmd) begin
                  sd_state   <= SD_REQ;
                  sd_command <= 1'b1;
                  sd_rw      <= o[0];
               end
            end
            SD_REQ: begin
               if (sd_busy) begin
                  sd_state   <= SD_WAIT;
                  sd_command <= 1'b0;
               end
            end
            SD_WAIT: begin
               if (sd_done) sd_state <= SD_IDLE;
            end
            default: begin
               sd_state   <= SD_IDLE;
               sd_command <= 1'b0;
            end
         endcase
      end
   end

   logic [7:0] pend_rd;

`ifdef IO_IRQ_EN
   logic wr_mask, wr_pend;
   logic [3:0] mask, pending, mask_next, pending_next, irq_src;

   assign wr_mask      = w && in_win && (idx == 4'd3);
   assign wr_pend      = w && in_win && (idx == 4'd9);
   assign irq_src      = {done_set, tick, p_vblank, p_kdone};
   assign pending_next = irq_src | (pending & ~(wr_pend ? o[3:0] : 4'h0));
   assign mask_next    = wr_mask ? o[3:0] : mask;
   assign pend_rd      = {4'h0, pending};

   // irq is registered from the next-state values so it follows a source pulse by one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mask    <= 4'h0;
         pending <= 4'h0;
         irq     <= 1'b0;
      end else begin
         mask    <= mask_next;
         pending <= pending_next;
         irq     <= |(pending_next & mask_next);
      end
   end
`else
   assign pend_rd = 8'h00;
   assign irq     = 1'b0;
`endif

   always_comb begin
      p = 8'h00;
      if (in_win) begin
         case (idx)
            4'd0:    p = (count != '0) ? kbd_mem[head] : 8'h00;
            4'd1:    p = tcount;
            4'd2:    p = {kbd_level, 2'b00, kbd_ovf, (count != '0)};
            4'd3:    p = {7'b0, vblank};
            4'd4:    p = sd_lba[7:0];
            4'd5:    p = sd_lba[15:8];
            4'd6:    p = sd_lba[23:16];
            4'd7:    p = sd_lba[31:24];
            4'd8:    p = {sd_error, sd_card, done, busy_flag};
            4'd9:    p = pend_rd;
            default: p = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_io_ports.sv
// tb_io_ports: directed and randomized checks of io_ports against a queue-based behavioural model.
module tb_io_ports;

   localparam logic [15:0] BASE = 16'h0020;
   localparam int DEPTH = 8;
   localparam int DIV   = 10;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [7:0]  o = 8'h00;
   logic        r = 1'b0, w = 1'b0;
   logic [7:0]  p;
   logic        sd_command, sd_rw;
   logic [31:0] sd_lba;
   logic [1:0]  sd_card = 2'b00;
   logic [3:0]  sd_error = 4'h0;
   logic        sd_done = 1'b0, sd_busy = 1'b0;
   logic        p_vpage;
   logic [2:0]  p_border;
   logic        p_vblank = 1'b0, p_kdone = 1'b0;
   logic [7:0]  p_ascii = 8'h00;
   logic        irq;

   always #5 clock = ~clock;

   io_ports #(.BASE(BASE), .KBD_DEPTH(DEPTH), .CLK_HZ(1000), .TIMER_HZ(100)) dut (
      .clock(clock), .reset_n(reset_n), .a(a), .o(o), .r(r), .w(w), .p(p),
      .sd_command(sd_command), .sd_rw(sd_rw), .sd_lba(sd_lba), .sd_card(sd_card),
      .sd_error(sd_error), .sd_done(sd_done), .sd_busy(sd_busy), .p_vpage(p_vpage),
      .p_border(p_border), .p_vblank(p_vblank), .p_kdone(p_kdone), .p_ascii(p_ascii),
      .irq(irq)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: key queue, flags, registers, SD phase (0 idle, 1 request, 2 wait).
   byte unsigned kq[$];
   bit        m_ovf, m_vb, m_done, m_vpage, m_cmd, m_rw, m_irq;
   bit [2:0]  m_border;
   bit [31:0] m_lba;
   bit [3:0]  m_pend, m_mask;
   int        m_phase, m_cyc;

   task automatic model_reset();
      kq.delete();
      m_ovf = 0; m_vb = 0; m_done = 0; m_vpage = 0; m_cmd = 0; m_rw = 0; m_irq = 0;
      m_border = 0; m_lba = 0; m_pend = 0; m_mask = 0; m_phase = 0; m_cyc = 0;
   endtask

   function automatic bit hit(input int k, input bit s);
      return s && (a == BASE + 16'(k));
   endfunction

   task automatic model_update();
      int sz;
      bit popv, dset, tick, ovf_set;
      byte unsigned dummy;
      if (!reset_n) begin
         model_reset();
         return;
      end
      sz      = kq.size();
      popv    = hit(0, r) && (sz > 0);
      tick    = ((m_cyc + 1) % DIV) == 0;
      dset    = (m_phase == 2) && sd_done;
      ovf_set = 0;
      if (popv) dummy = kq.pop_front();
      if (p_kdone) begin
         if (sz < DEPTH || popv) kq.push_back(p_ascii);
         else ovf_set = 1;
      end
      m_ovf  = ovf_set || (m_ovf && !hit(2, r));
      m_vb   = p_vblank || (m_vb && !hit(3, r));
      m_done = dset || (m_done && !hit(8, r));
      if (hit(0, w)) m_border = o[2:0];
      if (hit(1, w)) m_vpage = o[0];
      if (m_phase == 0) begin
         for (int k = 0; k < 4; k++)
            if (hit(4 + k, w)) m_lba[8*k +: 8] = o;
      end
      if (m_phase == 0 && hit(8, w)) begin
         m_phase = 1; m_cmd = 1; m_rw = o[0];
      end else if (m_phase == 1 && sd_busy) begin
         m_phase = 2; m_cmd = 0;
      end else if (m_phase == 2 && sd_done) begin
         m_phase = 0;
      end
`ifdef IO_IRQ_EN
      m_pend = {dset, tick, p_vblank, p_kdone} | (m_pend & ~(hit(9, w) ? o[3:0] : 4'h0));
      if (hit(3, w)) m_mask = o[3:0];
      m_irq = |(m_pend & m_mask);
`endif
      m_cyc++;
   endtask

   function automatic logic [7:0] exp_read(input logic [15:0] addr);
      logic [15:0] d;
      int sz, lv;
      d  = addr - BASE;
      sz = kq.size();
      lv = (sz > 15) ? 15 : sz;
      case (d)
         16'd0:   return (sz > 0) ? kq[0] : 8'h00;
         16'd1:   return 8'((m_cyc / DIV) % 256);
         16'd2:   return {4'(lv), 2'b00, m_ovf, (sz > 0)};
         16'd3:   return {7'b0, m_vb};
         16'd4:   return m_lba[7:0];
         16'd5:   return m_lba[15:8];
         16'd6:   return m_lba[23:16];
         16'd7:   return m_lba[31:24];
         16'd8:   return {sd_error, sd_card, m_done, (m_phase != 0) || sd_busy};
`ifdef IO_IRQ_EN
         16'd9:   return {4'h0, m_pend};
`endif
         default: return 8'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_output(input string tag);
      check({tag, ".cmd"},    sd_command, m_cmd);
      check({tag, ".rw"},     sd_rw,      m_rw);
      check({tag, ".lba"},    sd_lba,     m_lba);
      check({tag, ".border"}, p_border,   m_border);
      check({tag, ".vpage"},  p_vpage,    m_vpage);
      check({tag, ".irq"},    irq,        m_irq);
   endtask

   task automatic clk_step();
      @(posedge clock);
      model_update();
      #1;
      r = 0; w = 0; p_kdone = 0; p_vblank = 0; sd_done = 0;
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
      a = addr; o = data; w = 1;
      clk_step();
   endtask

   task automatic do_read(input logic [15:0] addr);
      a = addr; r = 1;
      #1;
      check($sformatf("rd%0h", addr), p, exp_read(addr));
      clk_step();
   endtask

   task automatic read_const(input logic [15:0] addr, input logic [7:0] exp, input string tag);
      a = addr; r = 1;
      #1;
      check(tag, p, exp);
      clk_step();
   endtask

   task automatic push_key(input logic [7:0] k);
      p_kdone = 1; p_ascii = k;
      clk_step();
   endtask

   task automatic apply_stimulus();
      int op;
      logic [15:0] addr;
      p_kdone  = ($urandom_range(0, 3) == 0);
      p_ascii  = 8'($urandom);
      p_vblank = ($urandom_range(0, 7) == 0);
      sd_busy  = 1'($urandom_range(0, 1));
      sd_done  = ($urandom_range(0, 5) == 0);
      sd_card  = 2'($urandom);
      sd_error = 4'($urandom);
      addr = ($urandom_range(0, 15) == 0) ? BASE - 16'd1 : BASE + 16'($urandom_range(0, 11));
      op = $urandom_range(0, 9);
      if (op < 5)      do_read(addr);
      else if (op < 8) do_write(addr, 8'($urandom));
      else             clk_step();
   endtask

   initial begin
      model_reset();
      sd_error = 4'hA; sd_card = 2'b01;
      clk_step(); clk_step();
      reset_n = 1;
      check_output("reset");
      read_const(BASE + 16'd2, 8'h00, "rst_stat");
      read_const(BASE + 16'd8, 8'hA4, "rst_sd");

      push_key(8'h41); push_key(8'h42);
      read_const(BASE + 16'd2, 8'h21, "stat_two");
      read_const(BASE, 8'h41, "key_a");
      read_const(BASE, 8'h42, "key_b");
      read_const(BASE, 8'h00, "key_empty");
      read_const(BASE + 16'd2, 8'h00, "stat_empty");

      for (int i = 0; i < 9; i++) push_key(8'h30 + 8'(i));
      read_const(BASE + 16'd2, 8'h83, "stat_ovf");
      read_const(BASE + 16'd2, 8'h81, "stat_ovf_clr");
      p_kdone = 1; p_ascii = 8'h55;
      read_const(BASE, 8'h30, "push_pop_full");
      read_const(BASE + 16'd2, 8'h81, "full_no_ovf");

      p_vblank = 1; clk_step();
      read_const(BASE + 16'd3, 8'h01, "vb_set");
      read_const(BASE + 16'd3, 8'h00, "vb_clr");
      p_vblank = 1; clk_step();
      p_vblank = 1;
      read_const(BASE + 16'd3, 8'h01, "vb_collide");
      read_const(BASE + 16'd3, 8'h01, "vb_set_wins");
      read_const(BASE + 16'd3, 8'h00, "vb_clr2");

      do_write(BASE, 8'hFD);
      do_write(BASE + 16'd1, 8'h01);
      check("border", p_border, 3'h5);
      check("vpage", p_vpage, 1'b1);

      do_write(BASE + 16'd4, 8'h78); do_write(BASE + 16'd5, 8'h56);
      do_write(BASE + 16'd6, 8'h34); do_write(BASE + 16'd7, 8'h12);
      do_write(BASE + 16'd8, 8'h01);
      check("sd_cmd_on", sd_command, 1'b1);
      check("sd_rw", sd_rw, 1'b1);
      check("sd_lba", sd_lba, 32'h12345678);
      clk_step();
      check("sd_cmd_hold", sd_command, 1'b1);
      do_write(BASE + 16'd8, 8'h00);
      check("sd_rw_ignored", sd_rw, 1'b1);
      do_write(BASE + 16'd4, 8'hFF);
      check("lba_locked", sd_lba, 32'h12345678);
      sd_busy = 1; clk_step();
      check("sd_cmd_off", sd_command, 1'b0);
      read_const(BASE + 16'd8, 8'hA5, "sd_busy_rd");
      sd_busy = 0; sd_done = 1; clk_step();
      read_const(BASE + 16'd8, 8'hA6, "sd_done_rd");
      read_const(BASE + 16'd8, 8'hA4, "sd_done_clr");
      check_output("after_sd");

      do_write(BASE + 16'd8, 8'h00);
      check("sd_cmd_again", sd_command, 1'b1);
      #2 reset_n = 0;
      #1;
      check("async_cmd_drop", sd_command, 1'b0);
      model_reset();
      check_output("reset_mid");
      clk_step();
      reset_n = 1;
      read_const(BASE + 16'd2, 8'h00, "rst_mid_stat");
      read_const(BASE + 16'd8, 8'hA4, "rst_mid_sd");

      while (m_cyc < 9) clk_step();
      read_const(BASE + 16'd1, 8'h00, "timer_pre");
      read_const(BASE + 16'd1, 8'h01, "timer_first");
      while (m_cyc < 2559) clk_step();
      read_const(BASE + 16'd1, 8'hFF, "timer_255");
      read_const(BASE + 16'd1, 8'h00, "timer_wrap");

`ifdef IO_IRQ_EN
      do_write(BASE + 16'd3, 8'h02);
      p_vblank = 1; clk_step();
      check("irq_vblank", irq, 1'b1);
      do_write(BASE + 16'd9, 8'h02);
      check("irq_cleared", irq, 1'b0);
      push_key(8'h61);
      check("irq_masked", irq, 1'b0);
`else
      do_write(BASE + 16'd9, 8'hFF);
      do_write(BASE + 16'd3, 8'hFF);
      p_vblank = 1; clk_step();
      read_const(BASE + 16'd9, 8'h00, "no_irq_pend");
      check("no_irq", irq, 1'b0);
`endif

      for (int i = 0; i < 600; i++) begin
         apply_stimulus();
         check_output("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
